// File: rtl/adc_capture_pkg.sv
// Shared constants for the ADC capture block: default widths, FIFO pointer width
// and the averaging group size.
package adc_capture_pkg;

  localparam int unsigned DATA_W_DEF     = 8;
  localparam int unsigned FIFO_DEPTH_DEF = 8;
  localparam int unsigned DIV_W_DEF      = 8;
  localparam int unsigned PTR_W          = $clog2(FIFO_DEPTH_DEF);
  localparam int unsigned AVG_GROUP      = 4;
  localparam int unsigned AVG_PHASE_W    = $clog2(AVG_GROUP);

  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/adc_sample_fifo.sv
// Synchronous sample FIFO; a push into a full FIFO is accepted only when a pop
// happens in the same cycle.
module adc_sample_fifo
  import adc_capture_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = FIFO_DEPTH_DEF,
  localparam int unsigned PtrW  = ptr_width(DEPTH),
  localparam int unsigned CntW  = PtrW + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop_ready,
  output logic [DATA_W-1:0] head_data,
  output logic [CntW-1:0]   count,
  output logic              full,
  output logic              empty
);

  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q;
  logic              pop, push_ok;

  assign empty     = (count_q == '0);
  assign full      = (count_q == DepthCnt);
  assign pop       = !empty && pop_ready;
  assign push_ok   = push && (!full || pop);
  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      // When full, wr_ptr == rd_ptr: the head is read this cycle before being overwritten.
      if (push_ok) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      if (push_ok && !pop) begin
        count_q <= count_q + CntW'(1);
      end else if (pop && !push_ok) begin
        count_q <= count_q - CntW'(1);
      end
    end
  end

endmodule

// File: rtl/adc_capture.sv
// ADC sample-clock generator and sample capture into a ready/valid FIFO.
// Optional 4-sample averaging is enabled by defining ADC_CAPTURE_AVG_EN.
module adc_capture
  import adc_capture_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int unsigned DIV_W      = DIV_W_DEF,
  localparam int unsigned CntW      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic [DIV_W-1:0]  clk_div,
  output logic              adc_clock,
  input  logic [DATA_W-1:0] adc_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CntW-1:0]   fifo_count,
  output logic              overflow,
  input  logic              overflow_clear
);

  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic              adc_clk_q, adc_clk_d;
  logic              div_wrap, strobe;
  logic [DATA_W-1:0] sample_q, sample_d;
  logic              sample_vld_q, sample_vld_d;
  logic              overflow_q, overflow_d;
  logic              fifo_full, fifo_empty, drop;

  // >= keeps a shrinking clk_div from letting the counter run away.
  assign div_wrap = (div_cnt_q >= clk_div);
  // Sample mid-period: on the cycle adc_clock is driven 1->0.
  assign strobe   = enable && div_wrap && adc_clk_q;

  always_comb begin
    div_cnt_d = div_cnt_q;
    adc_clk_d = adc_clk_q;
    if (!enable) begin
      div_cnt_d = '0;
      adc_clk_d = 1'b0;
    end else if (div_wrap) begin
      div_cnt_d = '0;
      adc_clk_d = !adc_clk_q;
    end else begin
      div_cnt_d = div_cnt_q + DIV_W'(1);
    end
  end

`ifdef ADC_CAPTURE_AVG_EN
  logic [DATA_W+1:0]      acc_q, acc_d, acc_sum;
  logic [AVG_PHASE_W-1:0] phase_q, phase_d;

  always_comb begin
    acc_sum      = acc_q + {2'b00, adc_data};
    acc_d        = acc_q;
    phase_d      = phase_q;
    sample_d     = sample_q;
    sample_vld_d = 1'b0;
    if (!enable) begin
      acc_d   = '0;
      phase_d = '0;
    end else if (strobe) begin
      if (phase_q == AVG_PHASE_W'(AVG_GROUP - 1)) begin
        sample_d     = acc_sum[DATA_W+1:2];
        sample_vld_d = 1'b1;
        acc_d        = '0;
        phase_d      = '0;
      end else begin
        acc_d   = acc_sum;
        phase_d = phase_q + AVG_PHASE_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q   <= '0;
      phase_q <= '0;
    end else begin
      acc_q   <= acc_d;
      phase_q <= phase_d;
    end
  end
`else
  always_comb begin
    sample_d     = strobe ? adc_data : sample_q;
    sample_vld_d = strobe;
  end
`endif

  // A full FIFO always has a head, so a pop happens exactly when out_ready is high.
  assign drop       = sample_vld_q && fifo_full && !out_ready;
  assign overflow_d = drop || (overflow_q && !overflow_clear);

  always_ff @(posedge clock) begin
    if (reset) begin
      div_cnt_q    <= '0;
      adc_clk_q    <= 1'b0;
      sample_q     <= '0;
      sample_vld_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      adc_clk_q    <= adc_clk_d;
      sample_q     <= sample_d;
      sample_vld_q <= sample_vld_d;
      overflow_q   <= overflow_d;
    end
  end

  adc_sample_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (sample_vld_q),
    .push_data (sample_q),
    .pop_ready (out_ready),
    .head_data (out_data),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign adc_clock = adc_clk_q;
  assign out_valid = !fifo_empty;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_adc_capture.sv
// Directed bench for adc_capture: divider timing, capture latency, FIFO overflow,
// enable/reset behaviour, and averaging when ADC_CAPTURE_AVG_EN is defined.
module tb_adc_capture;

  logic       clock;
  logic       reset;
  logic       enable;
  logic [7:0] clk_div;
  logic       adc_clock;
  logic [7:0] adc_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [3:0] fifo_count;
  logic       overflow;
  logic       overflow_clear;

  int n_tests = 0;
  int n_fail  = 0;
  int n;
  int guard;

  adc_capture dut (
    .clock          (clock),
    .reset          (reset),
    .enable         (enable),
    .clk_div        (clk_div),
    .adc_clock      (adc_clock),
    .adc_data       (adc_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .fifo_count     (fifo_count),
    .overflow       (overflow),
    .overflow_clear (overflow_clear)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Advance until adc_clock equals level; returns the number of cycles taken.
  task automatic wait_level(input logic level, output int cycles);
    cycles = 0;
    while (adc_clock !== level && cycles < 64) begin
      tick();
      cycles++;
    end
    if (adc_clock !== level) check("wait_adc_clock", 32'(adc_clock), 32'(level));
  endtask

  logic [7:0] drain_exp [8];

  initial begin
    drain_exp = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h09};
    reset = 1'b1; enable = 1'b0; clk_div = 8'd3; adc_data = 8'h00;
    out_ready = 1'b0; overflow_clear = 1'b0;
    tick();
    tick();
    check("rst_adc_clock", 32'(adc_clock), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_fifo_count", 32'(fifo_count), 0);
    check("rst_overflow", 32'(overflow), 0);
    reset = 1'b0;

`ifdef ADC_CAPTURE_AVG_EN
    // Groups of four: 0x10+0x11+0x12+0x14 = 0x47 -> 0x11; 0x40*3+0x44 = 0x104 -> 0x41.
    enable = 1'b1;
    clk_div = 8'd1;
    begin
      logic [7:0] avg_in [8];
      avg_in = '{8'h10, 8'h11, 8'h12, 8'h14, 8'h40, 8'h40, 8'h40, 8'h44};
      for (int i = 0; i < 8; i++) begin
        wait_level(1'b1, n);
        adc_data = avg_in[i];
        wait_level(1'b0, n);
        if (i == 2) check("avg_no_early_push", 32'(fifo_count), 0);
        if (i == 3) begin
          tick();
          check("avg_first_count", 32'(fifo_count), 1);
          check("avg_first_mean", 32'(out_data), 32'h11);
        end
      end
      tick();
      check("avg_second_count", 32'(fifo_count), 2);
    end
    out_ready = 1'b1;
    tick();
    check("avg_second_mean", 32'(out_data), 32'h41);
    out_ready = 1'b0;
    enable = 1'b0;
    tick();
`else
    // Divider timing with clk_div=3: first rise after 4 cycles, 4 high, 4 low.
    enable = 1'b1;
    out_ready = 1'b1;
    repeat (3) tick();
    check("first_rise_early", 32'(adc_clock), 0);
    tick();
    check("first_rise", 32'(adc_clock), 1);
    wait_level(1'b0, n);
    check("high_phase_cycles", n, 4);
    wait_level(1'b1, n);
    check("low_phase_cycles", n, 4);

    // Capture: value held over the high phase appears 2 cycles after the strobe.
    for (int k = 0; k < 3; k++) begin
      adc_data = 8'hA0 + 8'(k);
      wait_level(1'b0, n);
      check("cap_not_yet_valid", 32'(out_valid), 0);
      tick();
      check("cap_valid", 32'(out_valid), 1);
      check("cap_data", 32'(out_data), 32'(8'hA0 + 8'(k)));
      tick();
      check("cap_popped", 32'(out_valid), 0);
      wait_level(1'b1, n);
    end

    // Fill the FIFO with a ramp while the consumer stalls.
    out_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      adc_data = 8'(k);
      wait_level(1'b0, n);
      tick();
      check("ramp_count", 32'(fifo_count), 32'(k + 1));
      wait_level(1'b1, n);
    end
    check("full_no_overflow", 32'(overflow), 0);

    // 9th sample is dropped; a clear in the drop cycle loses to the set.
    adc_data = 8'h08;
    wait_level(1'b0, n);
    overflow_clear = 1'b1;
    tick();
    overflow_clear = 1'b0;
    check("drop_sets_overflow", 32'(overflow), 1);
    check("drop_count", 32'(fifo_count), 8);
    overflow_clear = 1'b1;
    tick();
    overflow_clear = 1'b0;
    check("overflow_cleared", 32'(overflow), 0);

    // Full with a pop in the push cycle: accepted, no overflow.
    wait_level(1'b1, n);
    adc_data = 8'h09;
    wait_level(1'b0, n);
    check("full_head", 32'(out_data), 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("push_pop_count", 32'(fifo_count), 8);
    check("push_pop_no_overflow", 32'(overflow), 0);
    check("push_pop_new_head", 32'(out_data), 1);

    // Disable mid-high-phase with clk_div=5.
    clk_div = 8'd5;
    wait_level(1'b1, n);
    adc_data = 8'hEE;
    tick();
    tick();
    enable = 1'b0;
    tick();
    check("disable_clock_low", 32'(adc_clock), 0);
    repeat (20) tick();
    check("disable_no_push", 32'(fifo_count), 8);

    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("drain_data", 32'(out_data), 32'(drain_exp[i]));
      tick();
    end
    check("drain_empty", 32'(out_valid), 0);
    out_ready = 1'b0;
`endif

    // Re-enable with clk_div=5: first rise after 6 cycles.
    clk_div = 8'd5;
    enable = 1'b1;
    repeat (5) tick();
    check("reenable_early", 32'(adc_clock), 0);
    tick();
    check("reenable_rise", 32'(adc_clock), 1);

`ifndef ADC_CAPTURE_AVG_EN
    // Reset with 5 samples buffered and adc_clock high.
    clk_div = 8'd1;
    guard = 0;
    while (!(fifo_count == 4'd5 && adc_clock) && guard < 200) begin
      tick();
      guard++;
    end
    check("pre_reset_count", 32'(fifo_count), 5);
    check("pre_reset_clock", 32'(adc_clock), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    enable = 1'b0;
    check("mid_rst_count", 32'(fifo_count), 0);
    check("mid_rst_valid", 32'(out_valid), 0);
    check("mid_rst_clock", 32'(adc_clock), 0);
    check("mid_rst_overflow", 32'(overflow), 0);
    repeat (3) tick();
    check("post_rst_count", 32'(fifo_count), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
